// File: rtl/weight_loader.sv
// Streams a header plus numWeight words into one of numNeuron weight memories.
// Define WEIGHT_LOADER_CKSUM_EN to require and check a trailing checksum word.
module weight_loader #(
   parameter int numWeight    = 3,
   parameter int numNeuron    = 5,
   parameter int addressWidth = 10,
   parameter int dataWidth    = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [dataWidth-1:0]    in_data,
   output logic [numNeuron-1:0]    wen,
   output logic [addressWidth-1:0] wadd,
   output logic [dataWidth-1:0]    win,
   output logic                    done,
   output logic                    err
);

`ifdef WEIGHT_LOADER_CKSUM_EN
   typedef enum logic [1:0] {IDLE, LOAD, CKSUM, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

   state_t                  r_state;
   logic [7:0]              r_sel;
   logic [addressWidth-1:0] r_cnt;
   logic [numNeuron-1:0]    r_wen;
   logic [addressWidth-1:0] r_wadd;
   logic [dataWidth-1:0]    r_win;
   logic                    r_done;
   logic                    r_err;
`ifdef WEIGHT_LOADER_CKSUM_EN
   logic [dataWidth-1:0]    r_sum;
`endif

   logic                    w_hs;
   logic                    w_sel_ok;
   logic                    w_last;
   logic [numNeuron-1:0]    w_onehot;

   assign w_hs     = in_valid & in_ready;
   assign w_sel_ok = int'(in_data[7:0]) < numNeuron;
   assign w_last   = (r_cnt == addressWidth'(numWeight - 1));
   assign w_onehot = numNeuron'(1) << r_sel;

   // Gated by rst_n so upstream never sees ready during reset.
   assign in_ready = rst_n & (r_state != DONE);

   assign wen  = r_wen;
   assign wadd = r_wadd;
   assign win  = r_win;
   assign done = r_done;
   assign err  = r_err;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_sel   <= '0;
         r_cnt   <= '0;
         r_wen   <= '0;
         r_wadd  <= '0;
         r_win   <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
`ifdef WEIGHT_LOADER_CKSUM_EN
         r_sum   <= '0;
`endif
      end else begin
         r_wen  <= '0;
         r_done <= 1'b0;
         r_err  <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_hs) begin
                  r_sel <= in_data[7:0];
                  r_cnt <= '0;
`ifdef WEIGHT_LOADER_CKSUM_EN
                  r_sum <= '0;
`endif
                  if (w_sel_ok) r_state <= LOAD;
                  else          r_err   <= 1'b1;
               end
            end
            LOAD: begin
               if (w_hs) begin
                  r_wen  <= w_onehot;
                  r_wadd <= r_cnt;
                  r_win  <= in_data;
`ifdef WEIGHT_LOADER_CKSUM_EN
                  r_sum  <= r_sum + in_data;
`endif
                  if (w_last) begin
`ifdef WEIGHT_LOADER_CKSUM_EN
                     r_state <= CKSUM;
`else
                     r_state <= DONE;
                     r_done  <= 1'b1;
`endif
                  end else begin
                     r_cnt <= r_cnt + addressWidth'(1);
                  end
               end
            end
`ifdef WEIGHT_LOADER_CKSUM_EN
            CKSUM: begin
               if (w_hs) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
                  r_err   <= (in_data != r_sum);
               end
            end
`endif
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: expected output events are queued by
// the stimulus and popped by an independent negedge monitor.
module tb_weight_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [4:0]  wen;
   logic [9:0]  wadd;
   logic [15:0] win;
   logic        done;
   logic        err;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [4:0]  wen;
      logic [9:0]  wadd;
      logic [15:0] win;
      logic        done;
      logic        err;
   } ev_t;

   ev_t q[$];

   weight_loader #(
      .numWeight(3), .numNeuron(5), .addressWidth(10), .dataWidth(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .wen(wen), .wadd(wadd), .win(win),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   // Monitor: every cycle with any output activity consumes one expected event.
   always @(negedge clk) begin
      ev_t e;
      if (rst_n === 1'b1 && (wen != 0 || done || err)) begin
         tests++;
         if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event got wen=%b wadd=%0d win=%h done=%b err=%b",
                     wen, wadd, win, done, err);
         end else begin
            e = q.pop_front();
            if (wen !== e.wen || done !== e.done || err !== e.err ||
                (e.wen != 0 && (wadd !== e.wadd || win !== e.win))) begin
               fails++;
               $display("FAIL event got wen=%b wadd=%0d win=%h done=%b err=%b expected wen=%b wadd=%0d win=%h done=%b err=%b",
                        wen, wadd, win, done, err,
                        e.wen, e.wadd, e.win, e.done, e.err);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge after the handshake edge.
   task automatic send(input logic [15:0] d);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         tests++;
         fails++;
         $display("FAIL send_timeout data=%h", d);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic push(input logic [4:0] w, input int a, input logic [15:0] d,
                       input logic dn, input logic er);
      ev_t e;
      e.wen  = w;
      e.wadd = 10'(a);
      e.win  = d;
      e.done = dn;
      e.err  = er;
      q.push_back(e);
   endtask

   task automatic load(input int n, input logic [15:0] w0, input logic [15:0] w1,
                       input logic [15:0] w2, input int gap,
                       input logic [15:0] cks, input logic cerr);
      logic [15:0] w [3];
      logic        last_done;
      w[0] = w0; w[1] = w1; w[2] = w2;
`ifdef WEIGHT_LOADER_CKSUM_EN
      last_done = 1'b0;
`else
      last_done = 1'b1;
`endif
      send(16'(n));
      for (int i = 0; i < 3; i++) begin
         if (gap > 0) idle(gap);
         push(5'(1 << n), i, w[i], (i == 2) ? last_done : 1'b0, 1'b0);
         send(w[i]);
      end
`ifdef WEIGHT_LOADER_CKSUM_EN
      push(5'b0, 0, 16'h0, 1'b1, cerr);
      send(cks);
`else
      if (cerr) $display("note: checksum %h unused in this build", cks);
`endif
      check("ready_low_in_done", 32'(in_ready), 32'h0);
   endtask

   task automatic check_reset_state();
      check("rst_wen",  32'(wen),  32'h0);
      check("rst_wadd", 32'(wadd), 32'h0);
      check("rst_win",  32'(win),  32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_err",  32'(err),  32'h0);
      check("rst_ready_after", 32'(in_ready), 32'h1);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      idle(2);
      check("ready_in_reset", 32'(in_ready), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_state();

      // Neuron 2, back-to-back weights
      load(2, 16'h0011, 16'h0022, 16'h0033, 0, 16'h0066, 1'b0);
      @(negedge clk);
      check("ready_after_done", 32'(in_ready), 32'h1);

      // Out-of-range header is rejected, then neuron 0 loads normally
      push(5'b0, 0, 16'h0, 1'b0, 1'b1);
      send(16'h0007);
      idle(2);
      check("ready_after_err", 32'(in_ready), 32'h1);
      load(0, 16'h000A, 16'h000B, 16'h000C, 0, 16'h0021, 1'b0);
      @(negedge clk);

      // Neuron 4 with 3-cycle valid gaps
      load(4, 16'h1234, 16'h5678, 16'h9ABC, 3, 16'h0368, 1'b0);
      @(negedge clk);

      // Reset in the middle of a load of neuron 3
      send(16'h0003);
      push(5'b01000, 0, 16'h0E01, 1'b0, 1'b0);
      send(16'h0E01);
      push(5'b01000, 1, 16'h0E02, 1'b0, 1'b0);
      send(16'h0E02);
      @(negedge clk);
      rst_n = 1'b0;
      idle(2);
      check("ready_in_mid_reset", 32'(in_ready), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_state();
      load(1, 16'h0101, 16'h0202, 16'h0303, 0, 16'h0606, 1'b0);
      @(negedge clk);
      check("ready_after_done2", 32'(in_ready), 32'h1);

      // Back-to-back loads: ready low only for the DONE cycle
      load(0, 16'hAAAA, 16'hBBBB, 16'hCCCC, 0, 16'h3331, 1'b0);
      @(negedge clk);
      check("ready_b2b", 32'(in_ready), 32'h1);
      load(1, 16'h0001, 16'h0002, 16'h0003, 0, 16'h0006, 1'b0);
      @(negedge clk);

`ifdef WEIGHT_LOADER_CKSUM_EN
      load(0, 16'h0001, 16'h0002, 16'h0003, 0, 16'h0006, 1'b0);
      @(negedge clk);
      load(0, 16'h0001, 16'h0002, 16'h0003, 0, 16'h0005, 1'b1);
      @(negedge clk);
`endif

      idle(5);
      check("queue_drained", 32'(q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
